// File: rtl/rmt_dest_demux.sv
// Routes whole AXI-Stream frames from the classifier to one of M_COUNT ports by first-beat tdest,
// with a single output register stage, per-port frame counters and a drop counter.
// state | meaning
// IDLE  | waiting for first beat of a frame
// FWD   | forwarding remaining beats to sel_reg
// DROP  | discarding remaining beats of an unroutable frame
module rmt_dest_demux #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH/8,
    parameter int USER_WIDTH = 8,
    parameter int DEST_WIDTH = 2,
    parameter int M_COUNT    = 2,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]            s_axis_tkeep,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    input  logic                             s_axis_tlast,
    input  logic [USER_WIDTH-1:0]            s_axis_tuser,
    input  logic [DEST_WIDTH-1:0]            s_axis_tdest,
    output logic [M_COUNT*DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [M_COUNT*KEEP_WIDTH-1:0]    m_axis_tkeep,
    output logic [M_COUNT-1:0]               m_axis_tvalid,
    input  logic [M_COUNT-1:0]               m_axis_tready,
    output logic [M_COUNT-1:0]               m_axis_tlast,
    output logic [M_COUNT*USER_WIDTH-1:0]    m_axis_tuser,
    output logic [M_COUNT*CNT_WIDTH-1:0]     stat_frame_count,
    output logic [CNT_WIDTH-1:0]             stat_drop_count
);

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    localparam logic [DEST_WIDTH:0] M_LIM = (DEST_WIDTH+1)'(M_COUNT);

    state_t                         state, state_nxt;
    logic                           run;
    logic [DEST_WIDTH-1:0]          sel_reg, sel_nxt;
    logic                           out_valid;
    logic [DATA_WIDTH-1:0]          data_reg;
    logic [KEEP_WIDTH-1:0]          keep_reg;
    logic [USER_WIDTH-1:0]          user_reg;
    logic                           last_reg;
    logic [M_COUNT-1:0]             sel_oh, cnt_oh;
    logic                           out_ready, take, dest_ok;
    logic                           s_fire, load, frame_done, drop_done;
    logic [M_COUNT-1:0][CNT_WIDTH-1:0] frame_cnt;
    logic [CNT_WIDTH-1:0]           drop_cnt;

    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < M_COUNT; i++) sel_oh[i] = (sel_reg == DEST_WIDTH'(i));
    end

    always_comb begin
        cnt_oh = '0;
        for (int i = 0; i < M_COUNT; i++) cnt_oh[i] = (sel_nxt == DEST_WIDTH'(i));
    end

    // The held beat always belongs to sel_reg, so its ready gates the input even in IDLE.
    assign out_ready = |(sel_oh & m_axis_tready);
    assign take      = out_valid && out_ready;
    assign dest_ok   = {1'b0, s_axis_tdest} < M_LIM;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        sel_nxt       = sel_reg;
        s_axis_tready = 1'b0;
        s_fire        = 1'b0;
        load          = 1'b0;
        frame_done    = 1'b0;
        drop_done     = 1'b0;
        case (state)
            IDLE: begin
                s_axis_tready = run && (!out_valid || out_ready);
                s_fire        = s_axis_tvalid && s_axis_tready;
                if (s_fire) begin
                    if (dest_ok) begin
                        sel_nxt = s_axis_tdest;
                        load    = 1'b1;
                        if (s_axis_tlast) frame_done = 1'b1;
                        else              state_nxt  = FWD;
                    end else begin
                        if (s_axis_tlast) drop_done = 1'b1;
                        else              state_nxt = DROP;
                    end
                end
            end
            FWD: begin
                s_axis_tready = run && (!out_valid || out_ready);
                s_fire        = s_axis_tvalid && s_axis_tready;
                if (s_fire) begin
                    load = 1'b1;
                    if (s_axis_tlast) begin
                        frame_done = 1'b1;
                        state_nxt  = IDLE;
                    end
                end
            end
            DROP: begin
                s_axis_tready = run;
                s_fire        = s_axis_tvalid && s_axis_tready;
                if (s_fire && s_axis_tlast) begin
                    drop_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run       <= 1'b0;
            sel_reg   <= '0;
            out_valid <= 1'b0;
            data_reg  <= '0;
            keep_reg  <= '0;
            user_reg  <= '0;
            last_reg  <= 1'b0;
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            run     <= 1'b1;
            sel_reg <= sel_nxt;
            if (load) begin
                out_valid <= 1'b1;
                data_reg  <= s_axis_tdata;
                keep_reg  <= s_axis_tkeep;
                user_reg  <= s_axis_tuser;
                last_reg  <= s_axis_tlast;
            end else if (take) begin
                out_valid <= 1'b0;
            end
            for (int i = 0; i < M_COUNT; i++)
                if (frame_done && cnt_oh[i]) frame_cnt[i] <= frame_cnt[i] + CNT_WIDTH'(1);
            if (drop_done) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
        end
    end

    assign m_axis_tdata     = {M_COUNT{data_reg}};
    assign m_axis_tkeep     = {M_COUNT{keep_reg}};
    assign m_axis_tuser     = {M_COUNT{user_reg}};
    assign m_axis_tlast     = {M_COUNT{last_reg}};
    assign m_axis_tvalid    = out_valid ? sel_oh : '0;
    assign stat_frame_count = frame_cnt;
    assign stat_drop_count  = drop_cnt;

endmodule

// File: doc/rmt_dest_demux.md
Name: rmt_dest_demux

Overview:
- Downstream neighbour of the RMT packet classifier in the app template datapath.
- Consumes the classifier's single AXI-Stream output together with its per-frame m_axis_tdest, and routes each whole frame to one of M_COUNT output AXI-Stream ports. Port 0 is the default path; port 1 is the function-0x0001 path.
- Frames whose tdest has no output port are consumed and dropped.
- Per-port frame counters and a drop counter are provided for app CSR readout.

Parameters:
DATA_WIDTH, 512, tdata width per port
KEEP_WIDTH, DATA_WIDTH/8, tkeep width
USER_WIDTH, 8, tuser width
DEST_WIDTH, 2, tdest width from classifier
M_COUNT, 2, number of output ports (1..2^DEST_WIDTH)
CNT_WIDTH, 32, statistics counter width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset; asynchronous, active-low
s_axis_tdata  in  DATA_WIDTH  input beat data
s_axis_tkeep  in  KEEP_WIDTH  input byte enables
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  input end of frame
s_axis_tuser  in  USER_WIDTH  input sideband
s_axis_tdest  in  DEST_WIDTH  destination; meaningful on first beat of frame
m_axis_tdata  out  M_COUNT*DATA_WIDTH  per-port data (all slices carry the same register)
m_axis_tkeep  out  M_COUNT*KEEP_WIDTH  per-port tkeep
m_axis_tvalid  out  M_COUNT  per-port valid; at most one bit set
m_axis_tready  in  M_COUNT  per-port ready
m_axis_tlast  out  M_COUNT  per-port last
m_axis_tuser  out  M_COUNT*USER_WIDTH  per-port user
stat_frame_count  out  M_COUNT*CNT_WIDTH  frames completed per port
stat_drop_count  out  CNT_WIDTH  frames dropped

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- While rst is low: state=IDLE, all m_axis_tvalid=0, s_axis_tready=0, counters=0, sel_reg=0. Data/keep/user/last output registers also clear to 0.
- First clock after rst deasserts: s_axis_tready=1.
- Transfer: a beat transfers when valid&&ready. The output slot is a single register stage: one beat buffered, latency 1 cycle from input accept to m_axis_tvalid.
- States:
  - IDLE: waiting for the first beat of a frame. On accept:
    - If s_axis_tdest < M_COUNT: latch sel_reg=s_axis_tdest and load the output register for port sel_reg. If tlast=0, go to FWD; otherwise count the frame and stay in IDLE.
    - If s_axis_tdest >= M_COUNT: the beat is discarded. If tlast=0, go to DROP; otherwise increment the drop count and stay in IDLE.
  - FWD: every accepted beat goes to port sel_reg. s_axis_tdest is ignored mid-frame. On accepted tlast: go to IDLE and increment stat_frame_count[sel_reg].
  - DROP: s_axis_tready=1 unconditionally and beats are discarded. On accepted tlast: go to IDLE and increment stat_drop_count.
- Ready:
  - In IDLE and FWD: s_axis_tready = !out_valid || m_axis_tready[out_port]. This is a combinational pass of the downstream ready, giving full throughput back-to-back.
  - In IDLE, the ready computation uses the port of the beat currently held in the output register, not the incoming dest.
- Output register:
  - Loads on input accept.
  - Clears valid when its beat is taken and no new beat is accepted in the same cycle.
  - Simultaneous take and accept: the new beat replaces the old one with no bubble.
- tvalid rules: m_axis_tvalid must not drop while asserted and un-taken. Data must be stable while valid && !ready.
- Frame atomicity: a frame never switches port mid-frame. A new frame to a different port may load in the same cycle the previous frame's last beat is taken.
- Counters:
  - Increment on accept of the tlast beat, not on downstream take.
  - Unsigned, wrap modulo 2^CNT_WIDTH with no saturation.
- Reset mid-frame: the held beat is discarded, the state returns to IDLE, and the next accepted beat is treated as a frame start.
- tkeep/tuser pass through unmodified. An all-zero tkeep beat is forwarded as-is.

Test Plan:
- Single-beat frame, tdest=0, m_axis_tready=11 -> m_axis_tvalid=01 one cycle after accept, data equal to input; stat_frame_count[0]=1.
- 4-beat frame with tdest=1 on beat 0 and tdest toggled to 0 on beats 1-3 -> all 4 beats on port 1, tlast on the 4th only; port 0 valid never asserts; stat_frame_count[1]=1.
- tdest=3 with M_COUNT=2, 3-beat frame -> s_axis_tready held 1, no m_axis_tvalid, stat_drop_count=1; a following tdest=0 frame is forwarded normally.
- Backpressure: port 0 frame with m_axis_tready[0]=0 for 5 cycles -> exactly one beat buffered, s_axis_tready=0, output data stable; release gives a 1 beat/cycle stream with no loss or duplication.
- Back-to-back frames port0 (2 beats) then port1 (2 beats), continuous valid, readies high -> 4 consecutive accept cycles, no bubble; port valid switches 01->10 on the beat after port 0's last.
- Assert rst low mid-frame in FWD with a held beat -> outputs valid=0 immediately (async); counters=0; after release, a 1-beat tdest=1 frame counts stat_frame_count[1]=1.
